// File: rtl/seq_mult_pkg.sv
// +----------------------------------------------------------------------------+
// | seq_mult_pkg                                                               |
// | Shared state encoding and width helpers for the shift-add multiplier.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package seq_mult_pkg;

    localparam int STATE_W   = 2;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    // A 2-bit operand still needs one counter bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult_datapath.sv
// +----------------------------------------------------------------------------+
// | seq_mult_datapath                                                          |
// | Operand registers, 2*WIDTH accumulator and add/subtract of shifted operand.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_mult_datapath #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 add,
    input  logic                 sub,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     in_1,
    input  logic [WIDTH-1:0]     in_2,
    input  logic [CNT_W-1:0]     cnt,
    output logic                 cur_bit,
    output logic                 signed_op,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH-1:0]   mplier;

    assign partial = mcand << cnt;
    assign cur_bit = mplier[cnt];

    always_comb begin
        acc_next = acc;
        if (add) begin
            acc_next = acc + partial;
        end else if (sub) begin
            acc_next = acc - partial;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            signed_op <= 1'b0;
        end else if (load) begin
            // Signed operands are sign-extended once so every partial product is already in 2*WIDTH form.
            mcand     <= {{WIDTH{op_signed & in_1[WIDTH-1]}}, in_1};
            mplier    <= in_2;
            acc       <= '0;
            signed_op <= op_signed;
        end else if (add || sub) begin
            acc       <= acc_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_mult_param.sv
// +----------------------------------------------------------------------------+
// | seq_mult_param                                                             |
// | Sequential shift-add multiplier, one multiplier bit per cycle.             |
// | SIGNED_MODE_EN adds the op_signed port for two's-complement operands.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_1,
    input  logic [WIDTH-1:0]     in_2,
`ifdef SIGNED_MODE_EN
    input  logic                 op_signed,
`endif
    output logic [2*WIDTH-1:0]   out,
    output logic                 ready,
    output logic                 done
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("seq_mult_param: WIDTH out of range 2..32");
        end
    endgenerate

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               step;
    logic               last;
    logic               neg;
    logic               add;
    logic               sub;
    logic               cur_bit;
    logic               signed_op;
    logic               op_signed_in;
    logic [2*WIDTH-1:0] acc_next;

`ifdef SIGNED_MODE_EN
    assign op_signed_in = op_signed;
`else
    assign op_signed_in = 1'b0;
`endif

    assign accept = ((state == IDLE) || (state == DONE)) && start;
    assign step   = (state == RUN);
    assign last   = (cnt == LAST_CNT);
    // The top multiplier bit carries negative weight in two's complement.
    assign neg    = last && signed_op;
    assign add    = step && cur_bit && !neg;
    assign sub    = step && cur_bit && neg;

    seq_mult_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .add       (add),
        .sub       (sub),
        .op_signed (op_signed_in),
        .in_1      (in_1),
        .in_2      (in_2),
        .cnt       (cnt),
        .cur_bit   (cur_bit),
        .signed_op (signed_op),
        .acc_next  (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        out   <= acc_next;
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_param.sv
// +----------------------------------------------------------------------------+
// | tb_seq_mult_param                                                          |
// | Self-checking bench: countdown reference model plus literal spot checks.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_mult_param;

    localparam int W  = 4;
    localparam int W8 = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [W-1:0]      in_1 = '0;
    logic [W-1:0]      in_2 = '0;
    logic              op_s = 1'b0;
    logic [2*W-1:0]    out;
    logic              ready;
    logic              done;

    logic              start8 = 1'b0;
    logic [W8-1:0]     a8 = '0;
    logic [W8-1:0]     b8 = '0;
    logic              op_s8 = 1'b0;
    logic [2*W8-1:0]   out8;
    logic              ready8;
    logic              done8;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_1      (in_1),
        .in_2      (in_2),
`ifdef SIGNED_MODE_EN
        .op_signed (op_s),
`endif
        .out       (out),
        .ready     (ready),
        .done      (done)
    );

    seq_mult_param #(.WIDTH(W8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .in_1      (a8),
        .in_2      (b8),
`ifdef SIGNED_MODE_EN
        .op_signed (op_s8),
`endif
        .out       (out8),
        .ready     (ready8),
        .done      (done8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] product(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        int x;
        int y;
        if (s) begin
            x = $signed(a);
            y = $signed(b);
        end else begin
            x = int'(a);
            y = int'(b);
        end
        return (2*W)'(x * y);
    endfunction

    // Reference: an accepted request yields its product exactly W edges later.
    logic [2*W-1:0] exp_out   = '0;
    logic           exp_ready = 1'b1;
    logic           exp_done  = 1'b0;
    logic [2*W-1:0] pending   = '0;
    int             remaining = 0;

    always @(posedge clk) begin
        bit sgn;
`ifdef SIGNED_MODE_EN
        sgn = op_s;
`else
        sgn = 1'b0;
`endif
        if (!rst) begin
            exp_out   = '0;
            exp_ready = 1'b1;
            exp_done  = 1'b0;
            remaining = 0;
        end else begin
            exp_done = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    exp_out   = pending;
                    exp_ready = 1'b1;
                    exp_done  = 1'b1;
                end
            end else if (start) begin
                pending   = product(in_1, in_2, sgn);
                remaining = W;
                exp_ready = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out",   64'(out),   64'(exp_out));
            check("model_ready", 64'(ready), 64'(exp_ready));
            check("model_done",  64'(done),  64'(exp_done));
        end
    end

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) check({name, "_timeout"}, 64'(done), 64'(1));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input logic [2*W-1:0] lit, input string name);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        in_1  = a;
        in_2  = b;
        op_s  = s;
        @(negedge clk);
        start = 1'b0;
        wait_done(name, cyc);
        check({name, "_latency"}, 64'(cyc), 64'(W));
        check({name, "_out"},     64'(out), 64'(lit));
    endtask

    task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b,
                        input logic [2*W8-1:0] lit, input string name);
        int cyc;
        @(negedge clk);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc),  64'(W8));
        check({name, "_out"},     64'(out8), 64'(lit));
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cyc;
        int pulses;
        bit prev_done;

        repeat (2) @(negedge clk);
        check("reset_out",   64'(out),   64'(0));
        check("reset_ready", 64'(ready), 64'(1));
        check("reset_done",  64'(done),  64'(0));
        chk_en = 1'b1;
        rst    = 1'b1;

        run_op(4'd6, 4'd9, 1'b0, 8'd54, "mul_6x9");
        run_op(4'd15, 4'd15, 1'b0, 8'hE1, "mul_15x15");
        run_op(4'd0, 4'd11, 1'b0, 8'd0, "mul_0x11");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(W'(a), W'(b), 1'b0, (2*W)'(a * b), "exhaustive");
            end
        end

        // Start held through RUN with changing operands.
        @(negedge clk);
        start = 1'b1;
        in_1  = 4'd3;
        in_2  = 4'd5;
        op_s  = 1'b0;
        @(negedge clk);
        in_1  = 4'd7;
        in_2  = 4'd2;
        wait_done("held1", cyc);
        check("held_first_out", 64'(out), 64'(15));
        @(negedge clk);
        start = 1'b0;
        wait_done("held2", cyc);
        check("held_second_out", 64'(out), 64'(14));
        idle(2);

        // Reset two cycles into a run.
        @(negedge clk);
        start = 1'b1;
        in_1  = 4'd5;
        in_2  = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out",   64'(out),   64'(0));
        check("midrst_ready", 64'(ready), 64'(1));
        check("midrst_done",  64'(done),  64'(0));
        rst = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'(0));

`ifdef SIGNED_MODE_EN
        run_op(4'h8, 4'h7, 1'b1, 8'hC8, "signed_m8x7");
        run_op(4'h8, 4'h8, 1'b1, 8'h40, "signed_m8xm8");
        run_op(4'hF, 4'hF, 1'b0, 8'hE1, "unsigned_15x15");
        run_op(4'hF, 4'h3, 1'b1, 8'hFD, "signed_m1x3");
`endif

        // Back-to-back: start held high, done must stay a single-cycle pulse.
        @(negedge clk);
        start     = 1'b1;
        pulses    = 0;
        prev_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            in_1 = W'($urandom);
            in_2 = W'($urandom);
            if (done === 1'b1) pulses++;
            if (prev_done && done === 1'b1) check("b2b_single_pulse", 64'(done), 64'(0));
            prev_done = done;
        end
        check("b2b_some_products", 64'(pulses > 5), 64'(1));
        idle(W + 2);

        // Randomised traffic including occasional resets.
        repeat (3000) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            in_1  = W'($urandom);
            in_2  = W'($urandom);
`ifdef SIGNED_MODE_EN
            op_s  = 1'($urandom_range(0, 1));
`else
            op_s  = 1'b0;
`endif
            rst   = ($urandom_range(0, 99) != 0);
        end
        rst = 1'b1;
        idle(W + 2);

        run8(8'd255, 8'd255, 16'hFE01, "w8_255x255");
        run8(8'd0, 8'd200, 16'h0000, "w8_0x200");
        run8(8'd13, 8'd17, 16'd221, "w8_13x17");

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
